// File: rtl/led_pattern_engine.sv
// LED pattern engine: shift / ping-pong / flash modes, programmable-rate prescaler,
// edge-detected mode and colour buttons, RGB-gated banks. Optional build macro: BTN_DEBOUNCE_EN.
module led_pattern_engine #(
  parameter int unsigned NB_LEDS     = 4,
  parameter int unsigned NB_COUNTER  = 14,
  parameter int unsigned NB_SW       = 4,
  parameter int unsigned NB_DEBOUNCE = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_SW-1:0]   i_btn,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b
);

  localparam int unsigned           NB_BTN  = 4;
  localparam logic [NB_COUNTER-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_SHIFT    = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_FLASH    = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    COL_R = 3'b100,
    COL_G = 3'b010,
    COL_B = 3'b001
  } colour_e;

  // ---------------------------------------------------------------------------
  // Button path: synchroniser, optional debounce, armed rising-edge detector
  // ---------------------------------------------------------------------------
  logic [NB_BTN-1:0] r_sync1;
  logic [NB_BTN-1:0] r_sync2;
  logic [NB_BTN-1:0] r_level_prev;
  logic [NB_BTN-1:0] r_armed;
  logic [NB_BTN-1:0] r_pulse;
  logic [1:0]        r_valid;
  logic [NB_BTN-1:0] w_level;

`ifdef BTN_DEBOUNCE_EN
  logic [NB_BTN-1:0]      r_dbnc_level;
  logic [NB_DEBOUNCE-1:0] r_dbnc_cnt [NB_BTN];

  // Level follows the synchronised input only after 2^NB_DEBOUNCE stable differing cycles.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_dbnc_level <= '0;
      for (int b = 0; b < int'(NB_BTN); b++) begin
        r_dbnc_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < int'(NB_BTN); b++) begin
        if (r_sync2[b] == r_dbnc_level[b]) begin
          r_dbnc_cnt[b] <= '0;
        end else if (&r_dbnc_cnt[b]) begin
          r_dbnc_level[b] <= r_sync2[b];
          r_dbnc_cnt[b]   <= '0;
        end else begin
          r_dbnc_cnt[b] <= r_dbnc_cnt[b] + NB_DEBOUNCE'(1);
        end
      end
    end
  end

  assign w_level = r_dbnc_level;
`else
  logic [NB_DEBOUNCE-1:0] w_unused_dbnc;
  assign w_unused_dbnc = '0;
  assign w_level       = r_sync2;
`endif

  // A button only arms once its synchronised input has been seen low after reset,
  // so a button held through reset cannot fire until released and pressed again.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_level_prev <= '0;
      r_armed      <= '0;
      r_pulse      <= '0;
      r_valid      <= '0;
    end else begin
      r_sync1      <= i_btn[NB_BTN-1:0];
      r_sync2      <= r_sync1;
      r_valid      <= {r_valid[0], 1'b1};
      r_level_prev <= w_level;
      r_armed      <= r_armed | (~r_sync2 & {NB_BTN{r_valid[1]}});
      r_pulse      <= w_level & ~r_level_prev & r_armed;
    end
  end

  if (NB_SW > NB_BTN) begin : g_unused_hi
    logic w_unused_hi;
    assign w_unused_hi = ^{i_sw[NB_SW-1:NB_BTN], i_btn[NB_SW-1:NB_BTN]};
  end

  // ---------------------------------------------------------------------------
  // Prescaler, mode FSM, pattern and colour
  // ---------------------------------------------------------------------------
  mode_e                  r_mode;
  mode_e                  w_mode_nxt;
  colour_e                r_colour;
  colour_e                w_colour_nxt;
  logic [NB_LEDS-1:0]     r_pattern;
  logic [NB_LEDS-1:0]     w_pattern_nxt;
  logic                   r_dir_up;
  logic                   w_dir_up_nxt;
  logic [NB_COUNTER-1:0]  r_cnt;
  logic [NB_COUNTER-1:0]  w_cnt_nxt;
  logic [NB_COUNTER-1:0]  w_limit;
  logic                   w_tick;
  logic [NB_LEDS-1:0]     r_led_r;
  logic [NB_LEDS-1:0]     r_led_g;
  logic [NB_LEDS-1:0]     r_led_b;

  assign w_limit = CNT_MAX >> i_sw[2:1];
  assign w_tick  = i_sw[0] && (r_cnt >= w_limit);

  // Next-state: a mode pulse wins over a coincident tick; colour is independent.
  always_comb begin
    w_mode_nxt    = r_mode;
    w_colour_nxt  = r_colour;
    w_pattern_nxt = r_pattern;
    w_dir_up_nxt  = r_dir_up;
    w_cnt_nxt     = r_cnt;

    if (i_sw[0]) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + NB_COUNTER'(1);
    end

    if (r_pulse[0]) begin
      w_cnt_nxt = '0;
      case (r_mode)
        MODE_SHIFT: begin
          w_mode_nxt    = MODE_PINGPONG;
          w_pattern_nxt = NB_LEDS'(1);
          w_dir_up_nxt  = 1'b1;
        end
        MODE_PINGPONG: begin
          w_mode_nxt    = MODE_FLASH;
          w_pattern_nxt = '0;
        end
        default: begin
          w_mode_nxt    = MODE_SHIFT;
          w_pattern_nxt = NB_LEDS'(1);
          w_dir_up_nxt  = 1'b1;
        end
      endcase
    end else if (w_tick) begin
      case (r_mode)
        MODE_SHIFT: begin
          if (i_sw[3]) begin
            w_pattern_nxt = {r_pattern[NB_LEDS-2:0], r_pattern[NB_LEDS-1]};
          end else begin
            w_pattern_nxt = {r_pattern[0], r_pattern[NB_LEDS-1:1]};
          end
        end
        MODE_PINGPONG: begin
          if (r_dir_up) begin
            if (r_pattern[NB_LEDS-1]) begin
              w_dir_up_nxt  = 1'b0;
              w_pattern_nxt = r_pattern >> 1;
            end else begin
              w_pattern_nxt = r_pattern << 1;
            end
          end else begin
            if (r_pattern[0]) begin
              w_dir_up_nxt  = 1'b1;
              w_pattern_nxt = r_pattern << 1;
            end else begin
              w_pattern_nxt = r_pattern >> 1;
            end
          end
        end
        default: begin
          w_pattern_nxt = ~r_pattern;
        end
      endcase
    end

    if (r_pulse[1]) begin
      w_colour_nxt = COL_R;
    end else if (r_pulse[2]) begin
      w_colour_nxt = COL_G;
    end else if (r_pulse[3]) begin
      w_colour_nxt = COL_B;
    end
  end

  // State register; colour banks are registered from next-state so they track o_led.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_mode    <= MODE_SHIFT;
      r_colour  <= COL_R;
      r_pattern <= NB_LEDS'(1);
      r_dir_up  <= 1'b1;
      r_cnt     <= '0;
      r_led_r   <= NB_LEDS'(1);
      r_led_g   <= '0;
      r_led_b   <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_colour  <= w_colour_nxt;
      r_pattern <= w_pattern_nxt;
      r_dir_up  <= w_dir_up_nxt;
      r_cnt     <= w_cnt_nxt;
      r_led_r   <= w_pattern_nxt & {NB_LEDS{w_colour_nxt == COL_R}};
      r_led_g   <= w_pattern_nxt & {NB_LEDS{w_colour_nxt == COL_G}};
      r_led_b   <= w_pattern_nxt & {NB_LEDS{w_colour_nxt == COL_B}};
    end
  end

  assign o_led   = r_pattern;
  assign o_led_r = r_led_r;
  assign o_led_g = r_led_g;
  assign o_led_b = r_led_b;

endmodule
